// File: rtl/instr_encoder_pkg.sv
// Shared ISA definitions: op_sel encoding, opcode/funct constants, FSM states
// and the control decoder used by the CPU front end.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_SLT  = 3'd4,
    OP_BEQ  = 3'd5,
    OP_ADDI = 3'd6,
    OP_SLTI = 3'd7
  } op_sel_e;

  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_BEQ   = 6'd4;
  localparam logic [5:0] OPC_ADDI  = 6'd8;
  localparam logic [5:0] OPC_SLTI  = 6'd10;

  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_SLT = 6'd42;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } enc_state_e;

  // Main-decoder control bundle driven from the opcode field.
  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;   // 1: destination is rd, 0: rt
    logic       branch;
    logic       alu_src;   // 1: second operand is the immediate
    logic [2:0] alu_op;
  } ctrl_t;

  // CPU main decoder; unknown opcodes decode to an all-zero (no-op) bundle.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OPC_RTYPE: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = 3'b000; end
      OPC_BEQ:   begin c.branch = 1'b1; c.alu_op = 3'b001; end
      OPC_ADDI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = 3'b010; end
      OPC_SLTI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = 3'b011; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle of the instruction encoder.
interface instr_encoder_if #(
  parameter int DEPTH = 32
);
  import instr_encoder_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          req_valid_i;
  logic          req_ready_o;
  op_sel_e       op_sel_i;
  logic [4:0]    rs_i;
  logic [4:0]    rt_i;
  logic [4:0]    rd_i;
  logic [15:0]   imm_i;
  logic          wr_en_o;
  logic [31:0]   wr_addr_o;
  logic [31:0]   wr_data_o;
  logic [CW-1:0] count_o;
  logic          full_o;

  // Requester side.
  modport master (
    output req_valid_i, op_sel_i, rs_i, rt_i, rd_i, imm_i,
    input  req_ready_o, wr_en_o, wr_addr_o, wr_data_o, count_o, full_o
  );

  // Encoder side.
  modport slave (
    input  req_valid_i, op_sel_i, rs_i, rt_i, rd_i, imm_i,
    output req_ready_o, wr_en_o, wr_addr_o, wr_data_o, count_o, full_o
  );

endinterface

// File: rtl/instr_encoder_pack.sv
// Purely combinational field packer: op_sel plus register/immediate fields
// into a 32-bit R-type or I-type instruction word.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  op_sel_e     op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word
);

  // Select the instruction format and opcode/funct for the requested op.
  always_comb begin
    // NOTE: default assignment first so every path drives word and no latch is inferred.
    word = '0;
    case (op_sel)
      OP_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
      OP_SUB:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB};
      OP_AND:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_AND};
      OP_OR:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR};
      OP_SLT:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT};
      OP_BEQ:  word = {OPC_BEQ,   rs, rt, imm};
      OP_ADDI: word = {OPC_ADDI,  rs, rt, imm};
      OP_SLTI: word = {OPC_SLTI,  rs, rt, imm};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts encode requests, packs them into instruction
// words and streams them into instruction memory at consecutive addresses,
// stopping once DEPTH words have been written.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  instr_encoder_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  enc_state_e    state_q;
  logic          wr_en_q;
  logic [31:0]   wr_addr_q;
  logic [31:0]   wr_data_q;
  logic [31:0]   ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   packed_word;
  logic          full;
  logic          ready;
  logic          accept;

  instr_pack u_pack (
    .op_sel (bus.op_sel_i),
    .rs     (bus.rs_i),
    .rt     (bus.rt_i),
    .rd     (bus.rd_i),
    .imm    (bus.imm_i),
    .word   (packed_word)
  );

  // Ready is gated by rst_i so nothing looks acceptable while reset is held.
  assign full   = (state_q == S_FULL);
  assign ready  = rst_i && !full && !clear_i;
  assign accept = bus.req_valid_i && ready;

  // Encoder FSM with registered write port, pointer and word count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
      ptr_q     <= BASE_ADDR;
      count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      wr_en_q <= 1'b0;
      if (clear_i) begin
        // A write registered last edge is already on the port this cycle;
        // only the bookkeeping restarts.
        state_q <= S_IDLE;
        ptr_q   <= BASE_ADDR;
        count_q <= '0;
      end else if (accept) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= ptr_q;
        wr_data_q <= packed_word;
        ptr_q     <= ptr_q + 32'd4;
        count_q   <= count_q + CW'(1);
        // FULL coincides with the last write's strobe.
        state_q   <= (count_q == CW'(DEPTH - 1)) ? S_FULL : S_WRITE;
      end else if (state_q == S_WRITE) begin
        state_q <= S_IDLE;
      end
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.wr_en_o     = wr_en_q;
  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.count_o     = count_q;
  assign bus.full_o      = full;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table over all op_sel values plus
// hand-written reset, back-to-back, full and clear sequences.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'd0;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b0;
  logic clear_i = 1'b0;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk_i = ~clk_i;

  instr_encoder_if #(.DEPTH(DEPTH)) bus ();

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .bus     (bus.slave)
  );

  typedef struct {
    op_sel_e     op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] exp_word;
    ctrl_t       exp_ctrl;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic v, input op_sel_e op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
    bus.req_valid_i = v;
    bus.op_sel_i    = op;
    bus.rs_i        = rs;
    bus.rt_i        = rt;
    bus.rd_i        = rd;
    bus.imm_i       = imm;
  endtask

  // One idle cycle with clear_i high, leaving clear_i low at the next negedge.
  task automatic do_clear();
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    //                 op       rs     rt     rd     imm        word           {rw,rdst,br,src,aluop}
    vecs[0] = '{OP_ADD,  5'd1,  5'd2,  5'd3,  16'h0000, 32'h00221820, '{1'b1,1'b1,1'b0,1'b0,3'b000}};
    vecs[1] = '{OP_SUB,  5'd4,  5'd5,  5'd6,  16'h1234, 32'h00853022, '{1'b1,1'b1,1'b0,1'b0,3'b000}};
    vecs[2] = '{OP_AND,  5'd31, 5'd31, 5'd31, 16'hFFFF, 32'h03FFF824, '{1'b1,1'b1,1'b0,1'b0,3'b000}};
    vecs[3] = '{OP_OR,   5'd7,  5'd0,  5'd9,  16'h0000, 32'h00E04825, '{1'b1,1'b1,1'b0,1'b0,3'b000}};
    vecs[4] = '{OP_SLT,  5'd10, 5'd11, 5'd12, 16'hABCD, 32'h014B602A, '{1'b1,1'b1,1'b0,1'b0,3'b000}};
    vecs[5] = '{OP_BEQ,  5'd2,  5'd3,  5'd31, 16'h0010, 32'h10430010, '{1'b0,1'b0,1'b1,1'b0,3'b001}};
    vecs[6] = '{OP_ADDI, 5'd0,  5'd8,  5'd7,  16'h0005, 32'h20080005, '{1'b1,1'b0,1'b0,1'b1,3'b010}};
    vecs[7] = '{OP_SLTI, 5'd9,  5'd1,  5'd0,  16'h8000, 32'h29218000, '{1'b1,1'b0,1'b0,1'b1,3'b011}};

    // Reset held low with a request pending: nothing may happen.
    drive_req(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0000);
    repeat (3) @(negedge clk_i);
    check("rst wr_en",   32'(bus.wr_en_o),     32'd0);
    check("rst ready",   32'(bus.req_ready_o), 32'd0);
    check("rst count",   32'(bus.count_o),     32'd0);
    check("rst full",    32'(bus.full_o),      32'd0);
    check("rst addr",    bus.wr_addr_o,        BASE);
    check("rst data",    bus.wr_data_o,        32'd0);

    // Release reset; add rs=1 rt=2 rd=3 is taken on the next edge.
    rst_i = 1'b1;
    #1 check("ready after rst", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk_i);
    check("add wr_en", 32'(bus.wr_en_o), 32'd1);
    check("add addr",  bus.wr_addr_o,    32'd0);
    check("add data",  bus.wr_data_o,    32'h00221820);
    check("add count", 32'(bus.count_o), 32'd1);
    bus.req_valid_i = 1'b0;
    @(negedge clk_i);
    check("idle wr_en", 32'(bus.wr_en_o), 32'd0);
    check("idle count", 32'(bus.count_o), 32'd1);

    // Back-to-back addi then beq.
    do_clear();
    drive_req(1'b1, OP_ADDI, 5'd0, 5'd8, 5'd0, 16'h0005);
    @(negedge clk_i);
    check("b2b0 wr_en", 32'(bus.wr_en_o), 32'd1);
    check("b2b0 addr",  bus.wr_addr_o,    32'd0);
    check("b2b0 data",  bus.wr_data_o,    32'h20080005);
    drive_req(1'b1, OP_BEQ, 5'd8, 5'd0, 5'd0, 16'hFFFE);
    @(negedge clk_i);
    check("b2b1 wr_en", 32'(bus.wr_en_o), 32'd1);
    check("b2b1 addr",  bus.wr_addr_o,    32'd4);
    check("b2b1 data",  bus.wr_data_o,    32'h1100FFFE);
    check("b2b1 count", 32'(bus.count_o), 32'd2);
    bus.req_valid_i = 1'b0;

    // Asynchronous reset in the middle of a write drops wr_en_o at once.
    do_clear();
    drive_req(1'b1, OP_OR, 5'd1, 5'd1, 5'd1, 16'h0000);
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    check("pre-abort wr_en", 32'(bus.wr_en_o), 32'd1);
    #1 rst_i = 1'b0;
    #1 check("abort wr_en", 32'(bus.wr_en_o), 32'd0);
    check("abort count", 32'(bus.count_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Five back-to-back requests into a DEPTH=4 encoder.
    do_clear();
    drive_req(1'b1, OP_ADD, 5'd1, 5'd2, 5'd0, 16'h0000);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      if (k <= 4) begin
        check($sformatf("full%0d wr_en", k), 32'(bus.wr_en_o),     32'd1);
        check($sformatf("full%0d addr", k),  bus.wr_addr_o,        32'((k - 1) * 4));
        check($sformatf("full%0d data", k),  bus.wr_data_o,        32'h00220020 | 32'((k - 1) << 11));
        check($sformatf("full%0d count", k), 32'(bus.count_o),     32'(k));
        check($sformatf("full%0d flag", k),  32'(bus.full_o),      32'(k == 4));
        check($sformatf("full%0d ready", k), 32'(bus.req_ready_o), 32'(k != 4));
      end else begin
        check("full5 wr_en", 32'(bus.wr_en_o),     32'd0);
        check("full5 count", 32'(bus.count_o),     32'd4);
        check("full5 flag",  32'(bus.full_o),      32'd1);
        check("full5 ready", 32'(bus.req_ready_o), 32'd0);
      end
      bus.rd_i = 5'(k);
    end
    bus.req_valid_i = 1'b0;

    // clear_i while a write is pending: the write completes at addr 4,
    // then the next accepted request restarts at addr 0.
    do_clear();
    check("clr from full", 32'(bus.full_o), 32'd0);
    drive_req(1'b1, OP_SUB, 5'd3, 5'd3, 5'd3, 16'h0000);
    @(negedge clk_i);
    check("clr w0 addr", bus.wr_addr_o, 32'd0);
    @(negedge clk_i);
    clear_i = 1'b1;
    #1 check("clr ready", 32'(bus.req_ready_o), 32'd0);
    check("clr pend wr_en", 32'(bus.wr_en_o), 32'd1);
    check("clr pend addr",  bus.wr_addr_o,    32'd4);
    @(negedge clk_i);
    check("clr edge wr_en", 32'(bus.wr_en_o), 32'd0);
    check("clr edge count", 32'(bus.count_o), 32'd0);
    clear_i = 1'b0;
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    check("post clr wr_en", 32'(bus.wr_en_o), 32'd1);
    check("post clr addr",  bus.wr_addr_o,    32'd0);
    check("post clr count", 32'(bus.count_o), 32'd1);

    // Vector table over all op_sel values, each from a fresh clear.
    foreach (vecs[i]) begin
      do_clear();
      drive_req(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm);
      @(negedge clk_i);
      bus.req_valid_i = 1'b0;
      check($sformatf("vec%0d wr_en", i), 32'(bus.wr_en_o), 32'd1);
      check($sformatf("vec%0d addr", i),  bus.wr_addr_o,    32'd0);
      check($sformatf("vec%0d word", i),  bus.wr_data_o,    vecs[i].exp_word);
      check($sformatf("vec%0d ctrl", i),  32'(decode_ctrl(bus.wr_data_o[31:26])), 32'(vecs[i].exp_ctrl));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, 32, instruction-memory capacity in 32-bit words (power of 2, 2..1024).
REQ-002 Parameter: BASE_ADDR, 0, byte address of the first written word.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 clear_i  input  1  synchronous restart: write pointer back to BASE_ADDR, full cleared.
REQ-006 req_valid_i  input  1  encode request present.
REQ-007 req_ready_o  output  1  encoder can accept a request this cycle.
REQ-008 op_sel_i  input  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 beq, 6 addi, 7 slti.
REQ-009 rs_i, rt_i, rd_i  input  5 each  register fields; rd_i is ignored for op_sel_i 5..7.
REQ-010 imm_i  input  16  immediate or branch offset in words; ignored for op_sel_i 0..4.
REQ-011 wr_en_o  output  1  instruction-memory write strobe.
REQ-012 wr_addr_o  output  32  byte address of the write.
REQ-013 wr_data_o  output  32  encoded instruction word.
REQ-014 count_o  output  clog2(DEPTH)+1  number of words written since reset or clear.
REQ-015 full_o  output  1  DEPTH words written; no further writes are accepted.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid_i and req_ready_o are both high.
REQ-017 req_ready_o SHALL equal !full_o && !clear_i.
REQ-018 Latency SHALL be 1 cycle: the edge that accepts a request registers wr_en_o=1, wr_addr_o and wr_data_o for the following cycle; throughput SHALL be one word per cycle.
REQ-019 wr_en_o SHALL be low in every cycle that follows a cycle without an accepted request.
REQ-020 R-type encoding (op_sel_i 0..4) SHALL be {6'd0, rs, rt, rd, 5'd0, funct}, with funct 32, 34, 36, 37, 42 for add, sub, and, or, slt.
REQ-021 I-type encoding SHALL be {opcode, rs, rt, imm}, with opcode 4 for beq, 8 for addi and 10 for slti.
REQ-022 The decode of opcode 0 (write rd, ALU op 000), 4 (branch, ALU op 001), 8 (immediate add, ALU op 010) and 10 (immediate slt, ALU op 011) by the CPU control decoder SHALL round-trip for every word this block emits.
REQ-023 The write pointer SHALL start at BASE_ADDR, advance by 4 per accepted request and never wrap.
REQ-024 FSM states SHALL be IDLE (no pending write), WRITE (wr_en_o high) and FULL:
  - IDLE→WRITE on accept.
  - WRITE→WRITE on accept.
  - WRITE→IDLE when no request is accepted.
  - Any→FULL when count_o reaches DEPTH; FULL is entered in the same cycle as the last write's wr_en_o.
  - FULL→IDLE only on clear_i or reset.
REQ-025 In FULL, req_ready_o SHALL be 0 and requests SHALL be ignored without side effects.
REQ-026 When clear_i is high:
  - No request SHALL be accepted.
  - A write already registered SHALL complete at its registered address.
  - The pointer, count_o and full_o SHALL reset on that edge.
REQ-027 count_o SHALL increment on the edge that accepts a request.

Reset
REQ-028 While rst_i=0, asynchronously:
  - state SHALL be IDLE and wr_en_o SHALL be 0.
  - wr_addr_o SHALL be BASE_ADDR; wr_data_o and count_o SHALL be 0.
  - full_o SHALL be 0; req_ready_o SHALL be 0.
REQ-029 A reset asserted mid-write SHALL abort that write immediately (wr_en_o falls without waiting for a clock edge).
REQ-030 The first request SHALL be accepted no earlier than the first rising edge after rst_i deasserts.

Structure
REQ-031 The opcode constants (0, 4, 8, 10), the funct constants (32, 34, 36, 37, 42) and the op_sel enumeration SHALL live in a shared package, also used by the CPU decoder and ALU control.
REQ-032 Encoding SHALL be one combinational sub-module, instr_pack (op_sel, rs, rt, rd, imm → 32-bit word), with all registers held in instr_encoder.

Verification
REQ-033 Reset with req_valid_i=1 held low-rst → no wr_en_o, req_ready_o=0, count_o=0.
REQ-034 add rs=1 rt=2 rd=3 → next cycle wr_en_o=1, wr_addr_o=0, wr_data_o=0x00221820.
REQ-035 Back-to-back addi rs=0 rt=8 imm=0x0005, then beq rs=8 rt=0 imm=0xFFFE → 0x20080005 @0 and 0x1100FFFE @4 on consecutive cycles.
REQ-036 DEPTH=4, 5 back-to-back requests → 4 writes (addr 0..12), full_o=1, 5th request never accepted, count_o=4.
REQ-037 clear_i asserted in the same cycle as a pending write → write lands at its registered address, next accepted request writes addr 0, count_o=1.
REQ-038 Encode all 8 op_sel values with random fields, decode opcode/funct → control outputs match the decoder table in REQ-022.
